// File: rtl/lab3_mem_arb_pkg.sv
// Shared definitions for the banked-cache memory port arbiter:
// ID width helper and the grant-lock state encoding.
package lab3_mem_arb_pkg;

    function automatic int id_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/lab3_mem_tag_fifo.sv
// In-order FIFO of requester IDs; the head names the bank that owns the
// next memory response.
module lab3_mem_tag_fifo
    import lab3_mem_arb_pkg::*;
#(
    parameter int p_depth = 4,
    parameter int p_width = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [p_width-1:0] push_data,
    output logic               full,
    output logic               empty,
    output logic [p_width-1:0] head
);

    localparam int PW = id_nbits(p_depth);
    localparam int CW = PW + 1;

    logic [p_width-1:0] mem_q [p_depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    assign full  = (count_q == CW'(p_depth));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/lab3_mem_mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among cache banks; the grant is
// held while memory stalls and responses are routed back via an ID FIFO.
module lab3_mem_mem_port_arbiter
    import lab3_mem_arb_pkg::*;
#(
    parameter int p_num_reqs     = 4,
    parameter int p_req_nbits    = 175,
    parameter int p_resp_nbits   = 145,
    parameter int p_max_inflight = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             req_val,
    output logic [p_num_reqs-1:0]             req_rdy,
    input  logic [p_num_reqs*p_req_nbits-1:0] req_msg,
    output logic [p_num_reqs-1:0]             resp_val,
    input  logic [p_num_reqs-1:0]             resp_rdy,
    output logic [p_resp_nbits-1:0]           resp_msg,
    output logic                              mem_req_val,
    input  logic                              mem_req_rdy,
    output logic [p_req_nbits-1:0]            mem_req_msg,
    input  logic                              mem_resp_val,
    output logic                              mem_resp_rdy,
    input  logic [p_resp_nbits-1:0]           mem_resp_msg
);

    localparam int ID_W = id_nbits(p_num_reqs);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(p_num_reqs - 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic [ID_W-1:0] pick, grant, head;
    logic            full, empty, fire, pop;

    // Scan from the farthest slot back to rr_ptr so the nearest valid wins.
    always_comb begin
        int idx;
        pick = rr_ptr_q;
        idx  = 0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % p_num_reqs;
            if (req_val[ID_W'(idx)]) pick = ID_W'(idx);
        end
    end

    assign grant       = (state_q == LOCKED) ? lock_id_q : pick;
    assign mem_req_val = reset && !full && ((state_q == LOCKED) || (|req_val));
    assign fire        = mem_req_val && mem_req_rdy;

    always_comb begin
        mem_req_msg = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (grant == ID_W'(i)) mem_req_msg = req_msg[i*p_req_nbits +: p_req_nbits];
        end
    end

    always_comb begin
        req_rdy = '0;
        if (reset && mem_req_rdy && !full) req_rdy[grant] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (fire) begin
            state_d  = UNLOCKED;
            rr_ptr_d = (grant == LAST_ID) ? '0 : grant + 1'b1;
        end else if (mem_req_val) begin
            state_d   = LOCKED;
            lock_id_d = grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= UNLOCKED;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Responses stall while no tag is outstanding rather than being dropped.
    always_comb begin
        resp_val = '0;
        if (mem_resp_val && !empty) resp_val[head] = 1'b1;
    end

    assign mem_resp_rdy = !empty && resp_rdy[head];
    assign resp_msg     = mem_resp_msg;
    assign pop          = mem_resp_val && mem_resp_rdy;

    lab3_mem_tag_fifo #(
        .p_depth (p_max_inflight),
        .p_width (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .pop       (pop),
        .push_data (grant),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

endmodule

// File: tb/tb_lab3_mem_mem_port_arbiter.sv
// Directed bench for the memory port arbiter with a scoreboard of expected
// response destinations.
module tb_lab3_mem_mem_port_arbiter;

    localparam int N  = 4;
    localparam int RQ = 175;
    localparam int RS = 145;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
    logic [N*RQ-1:0] req_msg;
    logic [RS-1:0]   resp_msg, mem_resp_msg;
    logic            mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [RQ-1:0]   mem_req_msg;
    logic [RQ-1:0]   msgs [N];

    int total = 0;
    int bad   = 0;
    int sb[$];

    lab3_mem_mem_port_arbiter #(
        .p_num_reqs     (N),
        .p_req_nbits    (RQ),
        .p_resp_nbits   (RS),
        .p_max_inflight (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_resp_msg (mem_resp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_msg = '0;
        for (int i = 0; i < N; i++) req_msg[i*RQ +: RQ] = msgs[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rsp_chk(input string tag);
        int b;
        logic [N-1:0] oh;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=response expected=empty_scoreboard", tag);
        end else begin
            b  = sb.pop_front();
            oh = 4'b0001 << b;
            chk(tag, 256'(resp_val), 256'(oh));
            chk({tag, "_rdy"}, 256'(mem_resp_rdy), 256'(1'b1));
        end
    endtask

    task automatic req_chk(input string tag, input int g);
        logic [N-1:0] oh;
        oh = 4'b0001 << g;
        chk({tag, "_val"}, 256'(mem_req_val), 256'(1'b1));
        chk({tag, "_rdy"}, 256'(req_rdy), 256'(oh));
        chk({tag, "_msg"}, 256'(mem_req_msg), 256'(msgs[g]));
        sb.push_back(g);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) msgs[i] = (RQ'(i + 1) << 150) | RQ'(32'h1000 * (i + 1) + 7 * i);

        // reset asserted with every input pulling outputs high
        reset = 1'b0; req_val = 4'hF; mem_req_rdy = 1'b1; mem_resp_val = 1'b1;
        resp_rdy = 4'hF; mem_resp_msg = RS'(145'h5A5A);
        #2;
        chk("rst_mem_req_val", 256'(mem_req_val), 256'(1'b0));
        chk("rst_req_rdy", 256'(req_rdy), 256'(4'b0000));
        chk("rst_resp_val", 256'(resp_val), 256'(4'b0000));
        chk("rst_mem_resp_rdy", 256'(mem_resp_rdy), 256'(1'b0));
        req_val = '0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0; resp_rdy = '0;
        tick();
        tick();
        reset = 1'b1;

        // single read from bank 2, response two cycles later
        req_val = 4'b0100; mem_req_rdy = 1'b1;
        #1;
        req_chk("t1_req", 2);
        tick();
        req_val = '0;
        tick();
        tick();
        mem_resp_val = 1'b1; resp_rdy = 4'hF; mem_resp_msg = RS'(145'hBEEF_0002);
        #1;
        rsp_chk("t1_resp");
        chk("t1_resp_msg", 256'(resp_msg), 256'(145'hBEEF_0002));
        tick();
        #1;
        chk("t1_empty_rdy", 256'(mem_resp_rdy), 256'(1'b0));
        chk("t1_empty_val", 256'(resp_val), 256'(4'b0000));
        mem_resp_val = 1'b0;
        req_val = 4'hF; mem_req_rdy = 1'b0;
        #1;
        chk("t1_rr3", 256'(mem_req_msg), 256'(msgs[3]));
        req_val = '0; mem_req_rdy = 1'b1;
        tick();

        // bring rr_ptr to 0, then all banks valid with streaming responses
        req_val = 4'b1000;
        #1;
        req_chk("t2_pre", 3);
        tick();
        for (int k = 0; k < 5; k++) begin
            req_val = 4'hF; mem_resp_val = 1'b1; resp_rdy = 4'hF;
            mem_resp_msg = RS'(100 + k);
            #1;
            rsp_chk($sformatf("t2_resp%0d", k));
            chk($sformatf("t2_rmsg%0d", k), 256'(resp_msg), 256'(100 + k));
            req_chk($sformatf("t2_req%0d", k), k % 4);
            tick();
        end
        req_val = '0;
        #1;
        rsp_chk("t2_drain");
        tick();
        mem_resp_val = 1'b0;

        // lock: banks 1 and 3 from rr_ptr 0 with memory stalled
        req_val = 4'b1000;
        #1;
        req_chk("t3_pre", 3);
        tick();
        req_val = '0; mem_resp_val = 1'b1;
        #1;
        rsp_chk("t3_pre_resp");
        tick();
        mem_resp_val = 1'b0;
        req_val = 4'b1010; mem_req_rdy = 1'b0;
        #1;
        chk("t3_c1_val", 256'(mem_req_val), 256'(1'b1));
        chk("t3_c1_msg", 256'(mem_req_msg), 256'(msgs[1]));
        chk("t3_c1_rdy", 256'(req_rdy), 256'(4'b0000));
        tick();
        req_val = 4'b1011;
        for (int k = 2; k <= 3; k++) begin
            #1;
            chk($sformatf("t3_c%0d_msg", k), 256'(mem_req_msg), 256'(msgs[1]));
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        req_chk("t3_c4", 1);
        tick();
        req_val = 4'b1101; mem_req_rdy = 1'b0;
        #1;
        chk("t3_rr2", 256'(mem_req_msg), 256'(msgs[2]));
        req_val = '0; mem_req_rdy = 1'b1;
        tick();
        mem_resp_val = 1'b1;
        #1;
        rsp_chk("t3_resp");
        tick();
        mem_resp_val = 1'b0;

        // fill the tag FIFO, then check the full condition
        req_val = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            req_chk($sformatf("t4_fill%0d", k), (2 + k) % 4);
            tick();
        end
        #1;
        chk("t4_full_val", 256'(mem_req_val), 256'(1'b0));
        chk("t4_full_rdy", 256'(req_rdy), 256'(4'b0000));
        tick();
        mem_resp_val = 1'b1;
        #1;
        chk("t4_pop_val", 256'(mem_req_val), 256'(1'b0));
        chk("t4_pop_rdy", 256'(req_rdy), 256'(4'b0000));
        rsp_chk("t4_pop");
        tick();
        mem_resp_val = 1'b0;
        #1;
        req_chk("t4_after", 2);
        tick();
        req_val = '0;

        // response blocked by bank 0 back-pressure, then empty-FIFO stall
        mem_resp_val = 1'b1; resp_rdy = 4'hF;
        #1;
        rsp_chk("t5_first");
        tick();
        resp_rdy = 4'b1110;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t5_hold_val%0d", k), 256'(resp_val), 256'(4'b0001));
            chk($sformatf("t5_hold_rdy%0d", k), 256'(mem_resp_rdy), 256'(1'b0));
            tick();
        end
        resp_rdy = 4'hF;
        #1;
        rsp_chk("t5_bank0");
        tick();
        rsp_chk("t5_bank1");
        tick();
        rsp_chk("t5_bank2");
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t5_empty_rdy%0d", k), 256'(mem_resp_rdy), 256'(1'b0));
            chk($sformatf("t5_empty_val%0d", k), 256'(resp_val), 256'(4'b0000));
            tick();
        end
        mem_resp_val = 1'b0;

        // two outstanding, lock on bank 2, then reset
        req_val = 4'b0011; mem_req_rdy = 1'b1;
        #1;
        req_chk("t6_req0", 0);
        tick();
        req_chk("t6_req1", 1);
        tick();
        req_val = 4'b0100; mem_req_rdy = 1'b0;
        #1;
        chk("t6_lock_msg", 256'(mem_req_msg), 256'(msgs[2]));
        tick();
        reset = 1'b0; req_val = 4'hF; mem_req_rdy = 1'b1; mem_resp_val = 1'b1; resp_rdy = 4'hF;
        #1;
        chk("t6_rst_mem_req_val", 256'(mem_req_val), 256'(1'b0));
        chk("t6_rst_req_rdy", 256'(req_rdy), 256'(4'b0000));
        chk("t6_rst_resp_val", 256'(resp_val), 256'(4'b0000));
        chk("t6_rst_mem_resp_rdy", 256'(mem_resp_rdy), 256'(1'b0));
        tick();
        reset = 1'b1;
        sb.delete();
        #1;
        chk("t6_post_empty", 256'(mem_resp_rdy), 256'(1'b0));
        chk("t6_post_resp_val", 256'(resp_val), 256'(4'b0000));
        req_chk("t6_post_grant", 0);
        tick();
        req_val = '0;
        #1;
        rsp_chk("t6_post_resp");
        tick();
        mem_resp_val = 1'b0;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
